// File: rtl/feeder_motor_pwm_multi.sv
// Multi-channel feeder dispense-motor controller: timed runs, cooldown lockout,
// and servo PWM whose pulses are gated only at period boundaries so none are cut short.
module feeder_motor_pwm_multi #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int N_CH       = 2,
    parameter int SEC_W      = 8,
    parameter int PWM_PERIOD = 1_000_000,
    parameter int HIGH_CYC   = 75_000,
    parameter int COOL_SEC   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         abort,
    input  logic [N_CH*SEC_W-1:0]   dur_sec,
    output logic [N_CH-1:0]         pwm,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         done
);

    localparam int COOL_CYC = COOL_SEC * CLK_HZ;
    localparam int SUB_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int COOL_W   = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
    localparam int PER_W    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'(CLK_HZ - 1);
    localparam logic [COOL_W-1:0] COOL_MAX = COOL_W'(COOL_CYC - 1);
    localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(PWM_PERIOD - 1);
    localparam logic [PER_W-1:0]  HIGH_LIM = PER_W'(HIGH_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_COOL
    } state_t;

    state_t            state_q [N_CH];
    state_t            state_d [N_CH];
    logic [SEC_W-1:0]  dur_q   [N_CH];
    logic [SEC_W-1:0]  dur_d   [N_CH];
    logic [SEC_W-1:0]  sec_q   [N_CH];
    logic [SEC_W-1:0]  sec_d   [N_CH];
    logic [SUB_W-1:0]  sub_q   [N_CH];
    logic [SUB_W-1:0]  sub_d   [N_CH];
    logic [COOL_W-1:0] cool_q  [N_CH];
    logic [COOL_W-1:0] cool_d  [N_CH];

    logic [N_CH-1:0]   gate_q, gate_d;
    logic [N_CH-1:0]   pwm_q, pwm_d;
    logic [N_CH-1:0]   busy_q, busy_d;
    logic [N_CH-1:0]   done_q, done_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic              wrap;

    always_comb begin
        wrap  = (per_q == PER_MAX);
        per_d = wrap ? '0 : per_q + PER_W'(1);
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            dur_d[i]   = dur_q[i];
            sec_d[i]   = sec_q[i];
            sub_d[i]   = sub_q[i];
            cool_d[i]  = cool_q[i];
            done_d[i]  = 1'b0;
            unique case (state_q[i])
                S_IDLE: begin
                    if (start[i] && !abort[i]) begin
                        if (dur_sec[i*SEC_W +: SEC_W] == '0) begin
                            done_d[i] = 1'b1;
                        end else begin
                            dur_d[i]   = dur_sec[i*SEC_W +: SEC_W];
                            sec_d[i]   = '0;
                            sub_d[i]   = '0;
                            state_d[i] = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort[i]) begin
                        cool_d[i] = '0;
                        if (COOL_CYC == 0) state_d[i] = S_IDLE;
                        else               state_d[i] = S_COOL;
                    end else if (sub_q[i] == SUB_MAX) begin
                        sub_d[i] = '0;
                        sec_d[i] = sec_q[i] + SEC_W'(1);
                        if (sec_d[i] == dur_q[i]) begin
                            done_d[i] = 1'b1;
                            cool_d[i] = '0;
                            if (COOL_CYC == 0) state_d[i] = S_IDLE;
                            else               state_d[i] = S_COOL;
                        end
                    end else begin
                        sub_d[i] = sub_q[i] + SUB_W'(1);
                    end
                end
                S_COOL: begin
                    if (cool_q[i] == COOL_MAX) state_d[i] = S_IDLE;
                    else cool_d[i] = cool_q[i] + COOL_W'(1);
                end
                default: state_d[i] = S_IDLE;
            endcase
            busy_d[i] = (state_d[i] != S_IDLE);
            // gate only moves on a period boundary, so pulses are always full width
            gate_d[i] = wrap ? (state_q[i] == S_RUN) : gate_q[i];
            pwm_d[i]  = gate_d[i] && (per_d < HIGH_LIM);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            per_q  <= '0;
            gate_q <= '0;
            pwm_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= S_IDLE;
                dur_q[i]   <= '0;
                sec_q[i]   <= '0;
                sub_q[i]   <= '0;
                cool_q[i]  <= '0;
            end
        end else begin
            per_q  <= per_d;
            gate_q <= gate_d;
            pwm_q  <= pwm_d;
            busy_q <= busy_d;
            done_q <= done_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                dur_q[i]   <= dur_d[i];
                sec_q[i]   <= sec_d[i];
                sub_q[i]   <= sub_d[i];
                cool_q[i]  <= cool_d[i];
            end
        end
    end

    assign pwm  = pwm_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_feeder_motor_pwm_multi.sv
// Bench for feeder_motor_pwm_multi: scenario tasks with done-time scoreboards
// and PWM shape checks against a reference period counter.
module tb_feeder_motor_pwm_multi;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] start = '0;
    logic [1:0] abort = '0;
    logic [7:0] dur_sec = '0;
    logic [1:0] pwm;
    logic [1:0] busy;
    logic [1:0] done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pc = 0;
    int exp_q0[$];
    int exp_q1[$];

    feeder_motor_pwm_multi #(
        .CLK_HZ(100), .N_CH(2), .SEC_W(4),
        .PWM_PERIOD(20), .HIGH_CYC(3), .COOL_SEC(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .dur_sec(dur_sec), .pwm(pwm), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // reference model of the shared period counter
    always @(posedge clock or negedge reset) begin
        if (!reset) pc <= 0;
        else        pc <= (pc == 19) ? 0 : pc + 1;
    end

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (pwm !== 2'b00) begin failures++; $display("FAIL rst_pwm got=%b exp=00", pwm); end
        checks++;
        if (busy !== 2'b00) begin failures++; $display("FAIL rst_busy got=%b exp=00", busy); end
        checks++;
        if (done !== 2'b00) begin failures++; $display("FAIL rst_done got=%b exp=00", done); end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({pwm, busy, done} !== 6'b0) begin
            failures++; $display("FAIL post_rst_outs got=%b exp=000000", {pwm, busy, done});
        end
    endtask

    task automatic test_run_and_pwm();
        int c0, rises, hi, last, e;
        bit p1;
        @(negedge clock);
        dur_sec[3:0] = 4'd3; start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        c0 = cyc;
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL busy0_rise got=%b exp=1", busy[0]); end
        exp_q0.push_back(c0 + 300);
        rises = 0; hi = 0; last = -1; p1 = 1'b0;
        for (int k = 0; k < 420; k++) begin
            if (done[0] === 1'b1) begin
                checks++;
                if (exp_q0.size() == 0) begin
                    failures++; $display("FAIL done0_unexpected got=%0d exp=none", cyc);
                end else begin
                    e = exp_q0.pop_front();
                    if (cyc !== e) begin failures++; $display("FAIL done0_time got=%0d exp=%0d", cyc, e); end
                end
            end
            if (pwm[1] !== 1'b0) p1 = 1'b1;
            if (pwm[0] === 1'b1) begin
                if (hi == 0) begin
                    rises++;
                    checks++;
                    if (pc !== 0) begin failures++; $display("FAIL pwm0_phase got=%0d exp=0", pc); end
                    if (last >= 0) begin
                        checks++;
                        if (cyc - last !== 20) begin
                            failures++; $display("FAIL pwm0_period got=%0d exp=20", cyc - last);
                        end
                    end
                    last = cyc;
                end
                hi++;
            end else if (hi != 0) begin
                checks++;
                if (hi !== 3) begin failures++; $display("FAIL pwm0_width got=%0d exp=3", hi); end
                hi = 0;
            end
            if (cyc == c0 + 399) begin
                checks++;
                if (busy[0] !== 1'b1) begin failures++; $display("FAIL busy0_cool got=%b exp=1", busy[0]); end
            end
            if (cyc == c0 + 400) begin
                checks++;
                if (busy[0] !== 1'b0) begin failures++; $display("FAIL busy0_fall got=%b exp=0", busy[0]); end
            end
            if (cyc == c0 + 100) begin
                start[0] = 1'b1; dur_sec[3:0] = 4'd7;
            end else if (cyc == c0 + 350) begin
                start[0] = 1'b1;
            end else begin
                start[0] = 1'b0;
            end
            @(negedge clock);
        end
        start[0] = 1'b0;
        checks++;
        if (exp_q0.size() != 0) begin failures++; $display("FAIL done0_missing got=0 exp=1"); end
        exp_q0.delete();
        checks++;
        if (rises !== 15) begin failures++; $display("FAIL pwm0_count got=%0d exp=15", rises); end
        checks++;
        if (p1 !== 1'b0) begin failures++; $display("FAIL pwm1_idle got=1 exp=0"); end
    endtask

    task automatic test_abort();
        int c0, a, extra;
        bit dn;
        @(negedge clock);
        dur_sec[3:0] = 4'd3; start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        c0 = cyc;
        while (cyc < c0 + 140) @(negedge clock);
        for (int k = 0; k < 25 && !(pwm[0] === 1'b1 && pc == 0); k++) @(negedge clock);
        checks++;
        if (pwm[0] !== 1'b1) begin failures++; $display("FAIL abort_setup got=%b exp=1", pwm[0]); end
        a = cyc; dn = 1'b0; extra = 0;
        abort[0] = 1'b1;
        @(negedge clock);
        abort[0] = 1'b0;
        while (cyc <= a + 130) begin
            if (done[0] !== 1'b0) dn = 1'b1;
            if (cyc == a + 1 || cyc == a + 2) begin
                checks++;
                if (pwm[0] !== 1'b1) begin failures++; $display("FAIL abort_tail got=%b exp=1", pwm[0]); end
            end
            if (cyc == a + 3) begin
                checks++;
                if (pwm[0] !== 1'b0) begin failures++; $display("FAIL abort_tail_end got=%b exp=0", pwm[0]); end
            end
            if (cyc > a + 3 && pwm[0] !== 1'b0) extra++;
            if (cyc == a + 100) begin
                checks++;
                if (busy[0] !== 1'b1) begin failures++; $display("FAIL abort_cool got=%b exp=1", busy[0]); end
            end
            if (cyc == a + 101 || cyc == a + 125) begin
                checks++;
                if (busy[0] !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", busy[0]); end
            end
            start[0] = (cyc == a + 50);
            @(negedge clock);
        end
        start[0] = 1'b0;
        checks++;
        if (dn !== 1'b0) begin failures++; $display("FAIL abort_done got=1 exp=0"); end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL abort_pwm got=%0d exp=0", extra); end
    endtask

    task automatic test_ignore_and_zero();
        int e;
        @(negedge clock);
        dur_sec[3:0] = 4'd2; start[0] = 1'b1; abort[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0; abort[0] = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            failures++; $display("FAIL start_abort got=%b%b exp=00", busy[0], done[0]);
        end
        dur_sec[7:4] = 4'd0; start[1] = 1'b1;
        exp_q1.push_back(cyc + 1);
        @(negedge clock);
        start[1] = 1'b0;
        checks++;
        if (done[1] !== 1'b1) begin
            failures++; $display("FAIL zero_done got=%b exp=1", done[1]);
        end else begin
            e = exp_q1.pop_front();
            if (cyc !== e) begin failures++; $display("FAIL zero_done_time got=%0d exp=%0d", cyc, e); end
        end
        exp_q1.delete();
        checks++;
        if (busy[1] !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy[1]); end
        @(negedge clock);
        checks++;
        if (done[1] !== 1'b0) begin failures++; $display("FAIL zero_pulse got=%b exp=0", done[1]); end
    endtask

    task automatic test_both_channels();
        int c0, e;
        int r[2];
        logic [1:0] pv;
        @(negedge clock);
        dur_sec = {4'd2, 4'd1}; start = 2'b11;
        @(negedge clock);
        start = 2'b00;
        c0 = cyc;
        exp_q0.push_back(c0 + 100);
        exp_q1.push_back(c0 + 200);
        r[0] = 0; r[1] = 0; pv = 2'b00;
        for (int k = 0; k < 320; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (done[ch] === 1'b1) begin
                    checks++;
                    if ((ch == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        failures++; $display("FAIL both_done%0d_unexpected got=%0d exp=none", ch, cyc);
                    end else begin
                        e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (cyc !== e) begin
                            failures++; $display("FAIL both_done%0d_time got=%0d exp=%0d", ch, cyc, e);
                        end
                    end
                end
                if (pwm[ch] === 1'b1 && pv[ch] === 1'b0) begin
                    r[ch]++;
                    checks++;
                    if (pc !== 0) begin failures++; $display("FAIL both_phase%0d got=%0d exp=0", ch, pc); end
                end
            end
            pv = pwm;
            if (cyc == c0 + 200) begin
                checks++;
                if (busy !== 2'b10) begin failures++; $display("FAIL both_busy200 got=%b exp=10", busy); end
            end
            if (cyc == c0 + 300) begin
                checks++;
                if (busy !== 2'b00) begin failures++; $display("FAIL both_busy300 got=%b exp=00", busy); end
            end
            @(negedge clock);
        end
        checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            failures++; $display("FAIL both_done_missing got=%0d exp=0", exp_q0.size() + exp_q1.size());
        end
        exp_q0.delete(); exp_q1.delete();
        checks++;
        if (r[0] !== 5 || r[1] !== 10) begin
            failures++; $display("FAIL both_pulses got=%0d/%0d exp=5/10", r[0], r[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        int c0, e;
        bit bad;
        @(negedge clock);
        dur_sec[3:0] = 4'd3; start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        c0 = cyc;
        while (cyc < c0 + 45) @(negedge clock);
        for (int k = 0; k < 25 && pwm[0] !== 1'b1; k++) @(negedge clock);
        checks++;
        if (pwm[0] !== 1'b1) begin failures++; $display("FAIL mid_setup got=%b exp=1", pwm[0]); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (pwm !== 2'b00) begin failures++; $display("FAIL mid_pwm got=%b exp=00", pwm); end
        checks++;
        if (busy !== 2'b00) begin failures++; $display("FAIL mid_busy got=%b exp=00", busy); end
        checks++;
        if (done !== 2'b00) begin failures++; $display("FAIL mid_done got=%b exp=00", done); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        bad = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (busy !== 2'b00 || pwm !== 2'b00 || done !== 2'b00) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL mid_idle got=1 exp=0"); end
        dur_sec[3:0] = 4'd1; start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        c0 = cyc;
        exp_q0.push_back(c0 + 100);
        for (int k = 0; k < 210; k++) begin
            if (done[0] === 1'b1) begin
                checks++;
                if (exp_q0.size() == 0) begin
                    failures++; $display("FAIL restart_unexpected got=%0d exp=none", cyc);
                end else begin
                    e = exp_q0.pop_front();
                    if (cyc !== e) begin failures++; $display("FAIL restart_done got=%0d exp=%0d", cyc, e); end
                end
            end
            if (cyc == c0 + 200) begin
                checks++;
                if (busy[0] !== 1'b0) begin failures++; $display("FAIL restart_busy got=%b exp=0", busy[0]); end
            end
            @(negedge clock);
        end
        checks++;
        if (exp_q0.size() != 0) begin failures++; $display("FAIL restart_missing got=0 exp=1"); end
        exp_q0.delete();
    endtask

    initial begin
        test_reset();
        test_run_and_pwm();
        test_abort();
        test_ignore_and_zero();
        test_both_channels();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
